// File: rtl/skolem_ult_or_seq_pkg.sv
// ============================================================================
// Module  : skolem_pkg
// Purpose : Shared FSM state type, mode constants and helpers for the
//           sequential (x|s) op t Skolem generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } skolem_state_e;

  localparam int SK_MODE_ULT = 0;
  localparam int SK_MODE_ULE = 1;

  // Bit-index register width; a 1-bit operand still needs a 1-bit index.
  function automatic int sk_idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skolem_ult_or_seq_prefix_le.sv
// ============================================================================
// Module  : skolem_prefix_le
// Purpose : Unsigned a <= b restricted to the bits selected by i_mask.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module skolem_prefix_le
  import skolem_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_mask,
  output logic         o_le
);

  logic [W-1:0] w_a_m;
  logic [W-1:0] w_b_m;

  assign w_a_m = i_a & i_mask;
  assign w_b_m = i_b & i_mask;
  assign o_le  = (w_a_m <= w_b_m);

endmodule

`default_nettype wire

// File: rtl/skolem_ult_or_seq.sv
// ============================================================================
// Module  : skolem_ult_or_seq
// Purpose : Maximal-witness generator for (x|s) < t (MODE 0) or <= t (MODE 1),
//           one witness bit per cycle MSB-first. Define SKOLEM_CHECK_EN to add
//           the sticky check_err self-check output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module skolem_ult_or_seq
  import skolem_pkg::*;
#(
  parameter int W    = 4,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sat,
  output logic [W-1:0] x
`ifdef SKOLEM_CHECK_EN
  ,
  output logic         check_err
`endif
);

  localparam int           IW    = sk_idx_w(W);
  localparam logic [W-1:0] c_one = W'(1);

  skolem_state_e r_state;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [W-1:0]  r_x;
  logic          r_sat;
  logic          r_tight;
  logic [IW-1:0] r_idx;
  logic          r_out_valid;

  logic [W-1:0]  w_b;
  logic          w_guard;
  logic [W-1:0]  w_lomask;
  logic [W-1:0]  w_mask;
  logic          w_le;
  logic          w_b_bit;

  // ULT becomes ULE against t-1; t==0 is rejected before the decrement matters.
  assign w_b     = (MODE == SK_MODE_ULT) ? (r_t - c_one) : r_t;
  assign w_guard = (MODE == SK_MODE_ULT) ? (r_t != '0) : 1'b1;

  // The one comparator does the full-width sat check in PREP and the
  // low-bit lookahead below the current index in SCAN.
  assign w_lomask = (c_one << r_idx) - c_one;
  assign w_mask   = (r_state == PREP) ? {W{1'b1}} : w_lomask;
  assign w_b_bit  = w_b[r_idx];

  skolem_prefix_le #(
    .W (W)
  ) u_prefix_le (
    .i_a    (r_s),
    .i_b    (w_b),
    .i_mask (w_mask),
    .o_le   (w_le)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_t         <= '0;
      r_x         <= '0;
      r_sat       <= 1'b0;
      r_tight     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s     <= s;
            r_t     <= t;
            r_state <= PREP;
          end
        end
        PREP: begin
          r_x   <= '0;
          r_sat <= w_guard & w_le;
          if (w_guard & w_le) begin
            r_tight <= 1'b1;
            r_idx   <= IW'(W - 1);
            r_state <= SCAN;
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        SCAN: begin
          if (!r_tight) begin
            r_x[r_idx] <= 1'b1;
          end else if (!w_b_bit) begin
            r_x[r_idx] <= 1'b0;
          end else if (w_le) begin
            r_x[r_idx] <= 1'b1;
          end else begin
            r_x[r_idx] <= 1'b0;
            r_tight    <= 1'b0;
          end
          if (r_idx == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sat       = r_sat;
  assign x         = r_x;

`ifdef SKOLEM_CHECK_EN
  logic         r_check_err;
  logic [W-1:0] w_or;
  logic         w_rel;

  assign w_or  = r_x | r_s;
  assign w_rel = (MODE == SK_MODE_ULT) ? (w_or < r_t) : (w_or <= r_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_check_err <= 1'b0;
    end else if ((r_state == DONE) &&
                 ((r_sat && !w_rel) || (!r_sat && (r_x != '0)))) begin
      r_check_err <= 1'b1;
    end
  end

  assign check_err = r_check_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skolem_ult_or_seq.sv
// ============================================================================
// Module  : tb_skolem_ult_or_seq
// Purpose : Scoreboard bench for skolem_ult_or_seq, one ULT and one ULE DUT.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_skolem_ult_or_seq;

  typedef struct packed {
    logic       sat;
    logic [3:0] x;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [1:0] sat;
  logic [3:0] s [2];
  logic [3:0] t [2];
  logic [3:0] x [2];
`ifdef SKOLEM_CHECK_EN
  logic [1:0] chk_err;
`endif

  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];

  skolem_ult_or_seq #(.W(4), .MODE(0)) u_ult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .s         (s[0]),
    .t         (t[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .sat       (sat[0]),
    .x         (x[0])
`ifdef SKOLEM_CHECK_EN
    ,
    .check_err (chk_err[0])
`endif
  );

  skolem_ult_or_seq #(.W(4), .MODE(1)) u_ule (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .s         (s[1]),
    .t         (t[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .sat       (sat[1]),
    .x         (x[1])
`ifdef SKOLEM_CHECK_EN
    ,
    .check_err (chk_err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input int m);
    exp_t e;
    checks++;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_output m=%0d got sat=%0b x=%b, required no output", m, sat[m], x[m]);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    if (sat[m] !== e.sat || x[m] !== e.x) begin
      errors++;
      $display("FAIL result m=%0d got sat=%0b x=%b, required sat=%0b x=%b",
               m, sat[m], x[m], e.sat, e.x);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid[0] && out_ready[0]) check_out(0);
    if (!rst && out_valid[1] && out_ready[1]) check_out(1);
  end

  task automatic issue(input int m, input logic [3:0] sv, input logic [3:0] tv,
                       input logic e_sat, input logic [3:0] e_x,
                       input bit push, input int e_lat);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready[m] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[m]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout m=%0d got in_ready=0, required 1", m);
      return;
    end
    in_valid[m] = 1'b1;
    s[m] = sv;
    t[m] = tv;
    @(posedge clk);
    if (push) begin
      if (m == 0) q0.push_back({e_sat, e_x});
      else        q1.push_back({e_sat, e_x});
    end
    @(negedge clk);
    in_valid[m] = 1'b0;
    s[m] = ~sv;
    t[m] = ~tv;
    if (e_lat > 0) begin
      lat = 1;
      while (!out_valid[m] && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != e_lat) begin
        errors++;
        $display("FAIL latency m=%0d s=%b t=%b got %0d cycles, required %0d",
                 m, sv, tv, lat, e_lat);
      end
    end
  endtask

  initial begin
    logic [3:0] hold_x;
    logic       hold_sat;
    logic [3:0] orv;
    logic       es;
    logic [3:0] ex;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    s[0] = '0; t[0] = '0; s[1] = '0; t[1] = '0;
    repeat (3) @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      checks++;
      if (in_ready[m] !== 1'b1 || out_valid[m] !== 1'b0 || sat[m] !== 1'b0 || x[m] !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state m=%0d got rdy=%0b vld=%0b sat=%0b x=%b, required 1 0 0 0000",
                 m, in_ready[m], out_valid[m], sat[m], x[m]);
      end
    end
    rst = 1'b0;

    // ULT directed
    issue(0, 4'b0001, 4'b1000, 1'b1, 4'b0111, 1, 6);
    issue(0, 4'b0101, 4'b0110, 1'b1, 4'b0101, 1, 6);
    issue(0, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1, 2);
    issue(0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1, 2);
    // ULE directed
    issue(1, 4'b0011, 4'b0110, 1'b1, 4'b0011, 1, 6);
    issue(1, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1, 6);
    issue(1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1, 6);
    issue(1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1, 2);

    // Backpressure: DONE held with stable outputs, new requests ignored.
    @(negedge clk);
    out_ready[0] = 1'b0;
    issue(0, 4'b0101, 4'b0110, 1'b1, 4'b0101, 1, 6);
    hold_x   = x[0];
    hold_sat = sat[0];
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = (k == 2);
      s[0] = 4'hF;
      t[0] = 4'hF;
      @(negedge clk);
      checks++;
      if (x[0] !== hold_x || sat[0] !== hold_sat || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL backpressure k=%0d got x=%b sat=%0b rdy=%0b vld=%0b, required x=%b sat=%0b rdy=0 vld=1",
                 k, x[0], sat[0], in_ready[0], out_valid[0], hold_x, hold_sat);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_idle got rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready[0], out_valid[0]);
    end

    // Reset two cycles into SCAN drops the request.
    issue(1, 4'b0011, 4'b0110, 1'b0, 4'b0000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || x[1] !== 4'b0000 || sat[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan got vld=%0b rdy=%0b x=%b sat=%0b, required 0 1 0000 0",
               out_valid[1], in_ready[1], x[1], sat[1]);
    end
    issue(1, 4'b0011, 4'b0110, 1'b1, 4'b0011, 1, 6);

    // Exhaustive sweep against a brute-force maximal witness.
    for (int md = 0; md < 2; md++) begin
      for (int si = 0; si < 16; si++) begin
        for (int ti = 0; ti < 16; ti++) begin
          es = 1'b0;
          ex = 4'b0000;
          for (int xi = 0; xi < 16; xi++) begin
            orv = 4'(xi) | 4'(si);
            if ((md == 0) ? (orv < 4'(ti)) : (orv <= 4'(ti))) begin
              es = 1'b1;
              ex = 4'(xi);
            end
          end
          issue(md, 4'(si), 4'(ti), es, ex, 1, 0);
        end
      end
    end

    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d, required 0/0", q0.size(), q1.size());
    end
`ifdef SKOLEM_CHECK_EN
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (chk_err[m] !== 1'b0) begin
        errors++;
        $display("FAIL check_err m=%0d got %0b, required 0", m, chk_err[m]);
      end
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/skolem_ult_or_seq.md
# skolem_ult_or_seq

Sequential, parametrised Skolem-function generator for the bit-vector constraint `(x | s) op t`, where `op` is unsigned-less-than or unsigned-less-or-equal. It accepts an (s, t) pair over a valid/ready handshake. It reports whether the constraint is satisfiable for some x and, if so, returns the maximal witness x, resolved MSB-first one bit per cycle. It sits in the Skolem-function library as the W-bit, multi-mode successor of the fixed-width combinational per-bit Skolem netlists, and feeds the invertibility-condition checker downstream.

## Interface
- `W`, 4: operand width, ≥1.
- `MODE`, 0: 0 = ULT (`(x|s) < t`), 1 = ULE (`(x|s) <= t`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept; high only in IDLE.
- `s` input W: fixed operand.
- `t` input W: bound.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `sat` output 1: a witness exists.
- `x` output W: maximal witness; 0 when `sat`=0.
- `check_err` output 1: self-check failure; present only with `SKOLEM_CHECK_EN`.

## Operation
- **FSM states:** IDLE, PREP, SCAN, DONE.
- **IDLE → PREP:** on `in_valid & in_ready`. `s` and `t` are registered; later input changes are ignored.
- **PREP:** computes the bound `b`.
  - ULT: `b = t - 1` (W-bit). Unsatisfiable if `t == 0`.
  - ULE: `b = t`.
  - `sat = (t-guard ok) & (s <= b)` (unsigned).
  - If `sat`=0: x=0 and go to DONE.
  - Otherwise: `tight`=1, bit index i=W-1, go to SCAN.
- **SCAN:** each cycle resolves `x[i]`, then decrements i.
  - If `!tight`: `x[i]=1`.
  - Else if `b[i]=0`: `x[i]=0`. `s[i]=0` is guaranteed by the sat check.
  - Else if `s[i-1:0] <= b[i-1:0]` (the lookahead; true when i=0): `x[i]=1` and `tight` stays 1.
  - Else: `x[i]=0`. `s[i]` is necessarily 0, so `tight`=0.
  - After i=0: go to DONE.
- **DONE:** `out_valid`=1. `x` and `sat` are held stable until `out_ready`; then go to IDLE.
- **Arithmetic:** all comparisons are unsigned W-bit. The ULT decrement never wraps because `t==0` is excluded first.
- **Reset values:** `rst` in any state (including mid-SCAN) → IDLE, `in_ready`=1, `out_valid`=0, `sat`=0, `x`=0, `check_err`=0. The in-flight request is dropped.

## Timing
- **Accept:** `in_ready` is combinational from state only. It never depends on `in_valid`.
- **Latency, sat:** W+2 cycles from the accept edge to `out_valid` (1 PREP + W SCAN + DONE entry).
- **Latency, unsat:** 2 cycles.
- **Throughput:** one request per W+3 cycles minimum, because `in_ready` is low outside IDLE.
- **Backpressure:** `out_ready` held low keeps DONE indefinitely with outputs stable.
- **No overlap:** `out_ready` asserted in the same cycle as `in_valid` is not bypassed. A new request is accepted only in the cycle after returning to IDLE.

## Configuration
- **`SKOLEM_CHECK_EN` defined:**
  - On DONE entry, recompute `(x|s) op t` from the registered operands.
  - `check_err` (sticky until `rst`) is set if `sat`=1 and the relation is false, or if `sat`=0 and `x`≠0.
- **`SKOLEM_CHECK_EN` undefined:** the `check_err` port and its logic are absent. All other behaviour is identical.

## Structure
- **Package `skolem_pkg`:**
  - state enum `skolem_state_e` (IDLE/PREP/SCAN/DONE);
  - mode constants `SK_MODE_ULT=0` and `SK_MODE_ULE=1`.
- **Sub-module `skolem_prefix_le`:** combinational W-bit unsigned `<=` on the masked low bits `[i-1:0]`, with a masking input. It serves both the PREP sat check (full mask) and the SCAN lookahead.

## Test plan
- **ULT, W=4:** s=0001, t=1000 → `sat`=1, x=0111, `out_valid` at cycle 6 after accept.
- **ULT, W=4:** s=0101, t=0110 → `sat`=1, x=0101. **ULE:** s=0011, t=0110 → x=0011 (lookahead fails at bit 2, loose afterwards).
- **ULT:** t=0000, any s → `sat`=0, x=0000, `out_valid` 2 cycles after accept. **ULT:** s=1000, t=1000 → `sat`=0. **ULE:** same operands → `sat`=1, x=1000.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → x and `sat` stable, `in_ready`=0, and a pulsed `in_valid` is ignored. Release → IDLE next cycle.
- **Reset mid-SCAN:** assert `rst` 2 cycles into SCAN → next cycle `out_valid`=0, `in_ready`=1, x=0. A fresh request then completes correctly.
- **`SKOLEM_CHECK_EN` build:** exhaustive W=4 sweep of all 256 (s,t) pairs in both modes → `check_err` stays 0. Each sat result is compared against a brute-force maximal x.
